// File: rtl/mem_wb_queue.sv
// MEM/WB result queue: circular FIFO between MEM and register-file write-back.
// Drains under valid/ready, honours the stall vector, flushes, and forwards.
module mem_wb_queue #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 7,
    parameter int STAGE   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STALL_W-1:0]           stall,
    input  logic                         flush,
    input  logic                         mem_valid,
    input  logic [ADDR_W-1:0]            mem_rd,
    input  logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_wreg,
    output logic                         mem_ready,
    output logic                         wb_valid,
    output logic [ADDR_W-1:0]            wb_rd,
    output logic [DATA_W-1:0]            wb_wdata,
    output logic                         wb_wreg,
    input  logic                         wb_ready,
    input  logic [ADDR_W-1:0]            fwd_raddr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] rd_q [DEPTH];
    logic [ADDR_W-1:0] rd_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  wreg_q, wreg_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        if (p == PTR_W'(DEPTH-1))
            return '0;
        return p + 1'b1;
    endfunction

    assign count     = count_q;
    assign mem_ready = (count_q != CNT_W'(DEPTH));
    assign wb_valid  = (count_q != '0);
    assign wb_rd     = wb_valid ? rd_q[head_q]   : '0;
    assign wb_wdata  = wb_valid ? data_q[head_q] : '0;
    assign wb_wreg   = wb_valid & wreg_q[head_q];
    assign push = mem_valid & mem_ready & ~stall[STAGE];
    assign pop  = wb_valid & wb_ready;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wreg_d  = wreg_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d = ptr_inc(head_q);
            end
            if (push) begin
                valid_d[tail_q] = 1'b1;
                rd_d[tail_q]    = mem_rd;
                data_d[tail_q]  = mem_wdata;
                wreg_d[tail_q]  = mem_wreg;
                tail_d = ptr_inc(tail_q);
            end
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        sum = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = {1'b0, head_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(DEPTH))
                sum = sum - (PTR_W+1)'(DEPTH);
            idx = sum[PTR_W-1:0];
            if (valid_q[idx] && wreg_q[idx] &&
                fwd_raddr != '0 &&
                rd_q[idx] == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wreg_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_queue.sv
// Bench for mem_wb_queue: scoreboard of expected write-backs
// plus per-scenario directed checks.
module tb_mem_wb_queue;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 4;
    localparam int STALL_W = 7;
    localparam int STAGE   = 3;
    localparam int CNT_W   = $clog2(DEPTH+1);

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              wreg;
    } ent_t;

    logic                clk = 0;
    logic                rst;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_rd;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_wreg;
    logic                mem_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_wdata;
    logic                wb_wreg;
    logic                wb_ready;
    logic [ADDR_W-1:0]   fwd_raddr;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic [CNT_W-1:0]    count;

    int   errors = 0;
    int   checks = 0;
    ent_t exp_q[$];
    int   mcount = 0;

    mem_wb_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .STALL_W(STALL_W), .STAGE(STAGE)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
        .mem_ready(mem_ready), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
        .wb_ready(wb_ready), .fwd_raddr(fwd_raddr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the reference model from the
    // inputs that were applied during the cycle.
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = mem_valid && (mcount < DEPTH) && !stall[STAGE];
        do_pop  = (mcount > 0) && wb_ready;
        e.rd   = mem_rd;
        e.data = mem_wdata;
        e.wreg = mem_wreg;
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                mcount--;
            end
            if (do_push) begin
                exp_q.push_back(e);
                mcount++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input int rd,
                         input int data, input logic wreg);
        mem_valid = v;
        mem_rd    = ADDR_W'(rd);
        mem_wdata = DATA_W'(data);
        mem_wreg  = wreg;
    endtask

    task automatic test_reset();
        rst = 1; tick(); rst = 0;
        #1;
        checks++;
        if (count !== '0 || wb_valid !== 1'b0 ||
            wb_rd !== '0 || wb_wdata !== '0 || wb_wreg !== 1'b0) begin
            errors++;
            $display("FAIL reset_wb: count=%0d valid=%b rd=%0d data=%h wreg=%b want 0",
                     count, wb_valid, wb_rd, wb_wdata, wb_wreg);
        end
        checks++;
        if (mem_ready !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== '0) begin
            errors++;
            $display("FAIL reset_misc: ready=%b hit=%b fdata=%h want 1 0 0",
                     mem_ready, fwd_hit, fwd_data);
        end
        // Reset in the middle of operation.
        wb_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            drive(1, k, k * 16, 1); tick();
        end
        drive(0, 0, 0, 0);
        checks++;
        if (count !== CNT_W'(mcount)) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d want %0d", count, mcount);
        end
        fwd_raddr = 2;
        rst = 1; tick(); rst = 0;
        #1;
        checks++;
        if (count !== '0 || wb_valid !== 1'b0 || wb_wreg !== 1'b0 ||
            mem_ready !== 1'b1 || fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d valid=%b wreg=%b ready=%b hit=%b",
                     count, wb_valid, wb_wreg, mem_ready, fwd_hit);
        end
        fwd_raddr = 0;
    endtask

    task automatic test_fill_drain();
        wb_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            drive(1, k, k * 'h11, 1); tick();
        end
        checks++;
        if (count !== CNT_W'(4) || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d ready=%b want 4 0", count, mem_ready);
        end
        // A fifth push, even with wb_ready high, must be refused.
        drive(1, 5, 'h55, 1);
        wb_ready = 1;
        #1;
        checks++;
        if (wb_rd !== ADDR_W'(1)) begin
            errors++;
            $display("FAIL full_head: got rd=%0d want 1", wb_rd);
        end
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (count !== CNT_W'(3) || mcount != 3) begin
            errors++;
            $display("FAIL no_passthru: count=%0d want 3", count);
        end
        for (int k = 2; k <= 4; k++) begin
            checks++;
            if (wb_valid !== 1'b1 || exp_q.size() == 0 ||
                wb_rd !== exp_q[0].rd || wb_wdata !== exp_q[0].data ||
                wb_rd !== ADDR_W'(k)) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b rd=%0d data=%h want rd=%0d",
                         k, wb_valid, wb_rd, wb_wdata, k);
            end
            tick();
        end
        checks++;
        if (count !== '0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: count=%0d valid=%b want 0 0",
                     count, wb_valid);
        end
    endtask

    task automatic test_stall();
        wb_ready = 0;
        drive(1, 3, 'h33, 1); tick();
        stall = 7'b0001000;
        drive(1, 6, 'h66, 1);
        wb_ready = 1;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== exp_q[0].rd ||
            wb_wdata !== exp_q[0].data) begin
            errors++;
            $display("FAIL bubble_head: valid=%b rd=%0d data=%h want rd=3",
                     wb_valid, wb_rd, wb_wdata);
        end
        tick();
        checks++;
        if (count !== '0 || mcount != 0) begin
            errors++;
            $display("FAIL bubble: count=%0d want 0", count);
        end
        stall = 7'b0011000;
        tick();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL hold: count=%0d want 0", count);
        end
        stall = '0;
        wb_ready = 0;
        tick();
        checks++;
        if (count !== CNT_W'(1) || wb_rd !== ADDR_W'(6) ||
            wb_wdata !== DATA_W'('h66)) begin
            errors++;
            $display("FAIL unstall: count=%0d rd=%0d data=%h want 1 6 66",
                     count, wb_rd, wb_wdata);
        end
        drive(0, 0, 0, 0);
        wb_ready = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        wb_ready = 1;
        for (int c = 0; c < 10; c++) begin
            drive(1, c + 1, c, 1);
            #1;
            if (c > 0) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_wdata !== DATA_W'(c - 1) ||
                    wb_wdata !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL b2b_data_%0d: valid=%b data=%0d want %0d",
                             c, wb_valid, wb_wdata, c - 1);
                end
            end
            tick();
            checks++;
            if (count !== CNT_W'(1)) begin
                errors++;
                $display("FAIL b2b_count_%0d: got %0d want 1", c, count);
            end
        end
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL b2b_end: count=%0d want 0", count);
        end
    endtask

    task automatic test_forward();
        logic [DATA_W-1:0] want;
        logic              hit;
        int                addrs [4];
        addrs = '{5, 7, 0, 9};
        wb_ready = 0;
        drive(1, 5, 'hA, 1); tick();
        drive(1, 7, 'hB, 1); tick();
        drive(1, 5, 'hC, 1); tick();
        drive(1, 9, 'hD, 0); tick();
        drive(0, 0, 0, 0);
        foreach (addrs[a]) begin
            fwd_raddr = ADDR_W'(addrs[a]);
            hit  = 0;
            want = '0;
            foreach (exp_q[i])
                if (exp_q[i].wreg && fwd_raddr != 0 &&
                    exp_q[i].rd == fwd_raddr) begin
                    hit  = 1;
                    want = exp_q[i].data;
                end
            #1;
            checks++;
            if (fwd_hit !== hit || fwd_data !== want) begin
                errors++;
                $display("FAIL fwd_%0d: hit=%b data=%h want %b %h",
                         addrs[a], fwd_hit, fwd_data, hit, want);
            end
        end
        fwd_raddr = 5;
        #1;
        checks++;
        if (fwd_data !== DATA_W'('hC)) begin
            errors++;
            $display("FAIL fwd_young: got %h want c", fwd_data);
        end
        wb_ready = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wb_rd !== exp_q[0].rd || wb_wdata !== exp_q[0].data ||
                wb_wreg !== exp_q[0].wreg) begin
                errors++;
                $display("FAIL fwd_drain_%0d: rd=%0d data=%h wreg=%b want %0d %h %b",
                         k, wb_rd, wb_wdata, wb_wreg,
                         exp_q[0].rd, exp_q[0].data, exp_q[0].wreg);
            end
            tick();
        end
        fwd_raddr = 0;
    endtask

    task automatic test_flush();
        wb_ready = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 10 + k, 'h100 + k, 1); tick();
        end
        checks++;
        if (count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL preflush: count=%0d want 3", count);
        end
        drive(1, 2, 'h222, 1);
        flush = 1;
        wb_ready = 1;
        tick();
        flush = 0;
        drive(0, 0, 0, 0);
        checks++;
        if (count !== '0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b want 0 0",
                     count, wb_valid);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wb_valid !== 1'b0 || wb_rd === ADDR_W'(2)) begin
                errors++;
                $display("FAIL flush_ghost_%0d: valid=%b rd=%0d want 0",
                         k, wb_valid, wb_rd);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1; stall = '0; flush = 0;
        drive(0, 0, 0, 0);
        wb_ready = 0;
        fwd_raddr = '0;
        #2;
        test_reset();
        test_fill_drain();
        test_stall();
        test_back_to_back();
        test_forward();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_queue.md
Name: mem_wb_queue

Overview:
- Parametrised successor to the single-register MEM/WB latch.
- Holds up to DEPTH completed MEM-stage results in a circular FIFO and drains them to register-file write-back under a valid/ready handshake.
- Keeps the global stall-vector semantics: advance, bubble or hold.
- Adds a pipeline flush and a youngest-match forwarding lookup across all queued entries.
- Sits between the MEM stage and the register file, replacing the fixed one-deep latch.

Parameters:
- DATA_W, 32, write-back data width.
- ADDR_W, 5, register address width.
- DEPTH, 4, number of queue entries; must be ≥2, need not be a power of two.
- STALL_W, 7, width of the global stall vector.
- STAGE, 3, index of this stage's bit in the stall vector; STAGE+1 must be < STALL_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stall  in  STALL_W  global stall vector; 1 = Stop
- flush  in  1  discard all queued entries
- mem_valid  in  1  MEM-stage result present
- mem_rd  in  ADDR_W  destination register
- mem_wdata  in  DATA_W  result data
- mem_wreg  in  1  result writes a register
- mem_ready  out  1  queue can accept an entry
- wb_valid  out  1  head entry present
- wb_rd  out  ADDR_W  head destination
- wb_wdata  out  DATA_W  head data
- wb_wreg  out  1  head write enable, gated by wb_valid
- wb_ready  in  1  register file consumes the head this cycle
- fwd_raddr  in  ADDR_W  forwarding lookup address
- fwd_hit  out  1  a queued entry matches
- fwd_data  out  DATA_W  data of the youngest match
- count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- **Reset.** rst=1 at a clock edge clears head/tail pointers and count, and clears the valid bit of every entry.
  - Combinationally this gives wb_valid=0, wb_rd=0, wb_wdata=0, wb_wreg=0, fwd_hit=0, fwd_data=0, count=0, mem_ready=1.
  - rst has priority over every other input, including mid-drain and full states.
- **Push qualification.**
  - push = mem_valid & mem_ready & (stall[STAGE]==0).
  - stall[STAGE]=1 with stall[STAGE+1]=0 is the bubble case: nothing is enqueued.
  - stall[STAGE]=1 with stall[STAGE+1]=1 is the hold case: nothing is enqueued.
  - Neither case affects draining.
- **Ready.** mem_ready = (count != DEPTH). There is no pass-through when full, even if wb_ready=1 in the same cycle.
- **Pop.** pop = wb_valid & wb_ready. Pop is independent of the stall vector.
- **Push and pop together.**
  - When both occur in one cycle, count is unchanged and both pointers advance.
  - Push into an empty queue: the entry appears on wb_* at the next cycle. Minimum latency is 1 cycle; there is no combinational bypass.
- **Pointer wrap.** Each pointer returns to 0 after reaching DEPTH-1.
- **Write-back outputs.**
  - wb_rd and wb_wdata come from the head entry when wb_valid=1, and are forced to 0 when the queue is empty.
  - wb_wreg = head.wreg & wb_valid.
- **Flush.**
  - Takes effect at the clock edge: pointers and count go to 0 and all valid bits clear.
  - A push presented in the same cycle is dropped.
  - A pop in the same cycle is irrelevant.
  - Flush is lower priority than rst.
- **Forwarding lookup (combinational).**
  - An entry matches when it is valid, has wreg=1, its rd equals fwd_raddr, and fwd_raddr != 0.
  - fwd_hit=1 if any entry matches.
  - fwd_data is the data of the youngest match, i.e. the one closest to the tail; otherwise fwd_data=0.
  - An entry popping this cycle still participates in the lookup.
  - The incoming mem_* value does not participate.
- **Register x0.** An entry with rd=0 is still queued and written back with wb_wreg as stored; only forwarding ignores x0.
- **Count.** Width is clog2(DEPTH+1). count never exceeds DEPTH and never underflows.

Test Plan:
- **Reset mid-operation.** With DEPTH=4, push 3 entries, then assert rst for 1 cycle → next cycle count=0, wb_valid=0, wb_wreg=0, mem_ready=1, fwd_hit=0.
- **Fill, full and drain order.**
  - With wb_ready=0, push rd=1..4 with data 0x11..0x44 → count=4 and mem_ready=0.
  - A 5th push (rd=5) is not accepted.
  - Then wb_ready=1 → rd 1,2,3,4 drain in order on consecutive cycles, and count reaches 0.
- **Stall vector.**
  - stall=7'b0001000 with mem_valid=1 → no enqueue (bubble), and a queued head still drains.
  - stall=7'b0011000 → no enqueue.
  - stall=0 → enqueue.
- **Simultaneous push, pop and wrap.**
  - Run 10 cycles of continuous push plus wb_ready=1 with DEPTH=4, data = cycle index → count stays 1.
  - Output data sequence equals input delayed by 1 cycle, across pointer wrap.
- **Forwarding youngest match.**
  - Queue rd=5/0xA, rd=7/0xB, rd=5/0xC; set fwd_raddr=5 → fwd_hit=1, fwd_data=0xC.
  - fwd_raddr=0 → fwd_hit=0.
  - An entry with wreg=0 and rd=9 does not hit for fwd_raddr=9.
- **Flush.**
  - Flush with count=3 while pushing rd=2 in the same cycle → next cycle count=0 and wb_valid=0.
  - The rd=2 entry never appears on wb_*.
